// File: rtl/jtframe_prog_pkg.sv
// Shared types for the ioctl-to-SDRAM programming path: queued write entry, DQM lane masks, request FSM states.
// Entry address is sized for the widest build (64 MB); narrower builds use the low SDRAMW bits.
package jtframe_prog_pkg;

  localparam int PROG_AW = 23;

  localparam logic [1:0] MASK_WORD = 2'b00;
  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;

  typedef struct packed {
    logic [1:0]         ba;
    logic [PROG_AW-1:0] addr;
    logic [15:0]        data;
    logic [1:0]         mask;
  } prog_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } prog_st_e;

  function automatic prog_entry_t make_entry(input logic [1:0] ba, input logic [PROG_AW-1:0] addr,
                                             input logic [15:0] data, input logic [1:0] mask);
    prog_entry_t e;
    e.ba   = ba;
    e.addr = addr;
    e.data = data;
    e.mask = mask;
    return e;
  endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Synchronous FIFO of prog_entry_t, 2**AW deep, head visible combinationally; zero-cycle read, one-cycle write.
// A push while full is refused (drop pulses) unless a pop happens in the same cycle.
module jtframe_prog_fifo
  import jtframe_prog_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  prog_entry_t din,
  input  logic        pop,
  output prog_entry_t dout,
  output logic        full,
  output logic        empty,
  output logic        drop
);

  localparam int DEPTH = 1 << AW;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  prog_entry_t   mem_q [DEPTH];

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    drop     = push & ~do_push;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/jtframe_prog_packer.sv
// Packs the byte-wide ioctl download into 16-bit SDRAM write requests; 2 clk strobe to prog_we, requests held until prog_rdy.
// Entries queue in a FIFO while the controller is busy, overflow drops are sticky; JTFRAME_PROG_HEADER_EN skips a HEADER-byte prefix.
module jtframe_prog_packer
  import jtframe_prog_pkg::*;
#(
  parameter int          SDRAMW    = 22,
  parameter logic [24:0] BA1_START = 25'h10_0000,
  parameter logic [24:0] BA2_START = 25'h18_0000,
  parameter logic [24:0] BA3_START = 25'h1C_0000,
  parameter int          FIFOAW    = 2,
  parameter int          HEADER    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);

`ifdef JTFRAME_PROG_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam logic [24:0] HDR_LEN = HDR_EN ? 25'(HEADER) : 25'd0;

  // input decode
  logic [24:0]       eff_addr, bank_start, off;
  logic [1:0]        in_ba;
  logic [SDRAMW-1:0] in_word;
  logic              in_lane, in_hdr, strobe;

  logic down_q, down_d, rise, fall, flush_req;
  logic hold_vld_q, hold_vld_d, hold_vld_eff;
  logic [1:0]        hold_ba_q, hold_ba_d;
  logic [SDRAMW-1:0] hold_word_q, hold_word_d;
  logic [7:0]        hold_dat_q, hold_dat_d;
  logic              pend_vld_q, pend_vld_d;
  prog_entry_t       pend_q, pend_d;
  logic              flush_pend_q, flush_pend_d;
  logic              overflow_q, overflow_d;

  prog_entry_t hold_ent, hi_ent, merged_ent, push_ent, fifo_head;
  logic        push_vld, pop, fifo_full, fifo_empty, fifo_drop;

  prog_st_e    state_q, state_d;
  prog_entry_t prog_ent_q, prog_ent_d;
  logic        prog_we_q, prog_we_d, load;
  logic        unused_bits;

  always_comb begin
    in_hdr   = HDR_EN && (ioctl_addr < HDR_LEN);
    eff_addr = ioctl_addr - HDR_LEN;
    if (eff_addr >= BA3_START) begin
      in_ba = 2'd3; bank_start = BA3_START;
    end else if (eff_addr >= BA2_START) begin
      in_ba = 2'd2; bank_start = BA2_START;
    end else if (eff_addr >= BA1_START) begin
      in_ba = 2'd1; bank_start = BA1_START;
    end else begin
      in_ba = 2'd0; bank_start = 25'd0;
    end
    // offsets past the bank size wrap: the upper bits are simply dropped
    off     = eff_addr - bank_start;
    in_word = off[SDRAMW:1];
    in_lane = off[0];
    strobe  = ioctl_wr & ~in_hdr;
  end

  assign down_d       = downloading;
  assign rise         = downloading & ~down_q;
  assign fall         = ~downloading & down_q;
  assign flush_req    = fall | flush_pend_q;
  assign hold_vld_eff = hold_vld_q & ~rise;
  assign overflow_d   = (overflow_q & ~rise) | fifo_drop;

  assign hold_ent   = make_entry(hold_ba_q, PROG_AW'(hold_word_q), {2{hold_dat_q}}, MASK_LO);
  assign hi_ent     = make_entry(in_ba, PROG_AW'(in_word), {2{ioctl_dout}}, MASK_HI);
  assign merged_ent = make_entry(in_ba, PROG_AW'(in_word), {ioctl_dout, hold_dat_q}, MASK_WORD);

  // One FIFO push per cycle; the second push of a strobe waits one cycle in pend.
  // Strobe spacing guarantees pend is empty when the next strobe arrives.
  always_comb begin
    hold_vld_d   = hold_vld_eff;
    hold_ba_d    = hold_ba_q;
    hold_word_d  = hold_word_q;
    hold_dat_d   = hold_dat_q;
    pend_vld_d   = pend_vld_q;
    pend_d       = pend_q;
    flush_pend_d = 1'b0;
    push_vld     = 1'b0;
    push_ent     = '0;
    if (pend_vld_q) begin
      push_vld     = 1'b1;
      push_ent     = pend_q;
      pend_vld_d   = 1'b0;
      flush_pend_d = flush_req;
    end else if (strobe) begin
      flush_pend_d = flush_req;
      if (!in_lane) begin
        push_vld    = hold_vld_eff;
        push_ent    = hold_ent;
        hold_vld_d  = 1'b1;
        hold_ba_d   = in_ba;
        hold_word_d = in_word;
        hold_dat_d  = ioctl_dout;
      end else if (hold_vld_eff && hold_ba_q == in_ba && hold_word_q == in_word) begin
        push_vld   = 1'b1;
        push_ent   = merged_ent;
        hold_vld_d = 1'b0;
      end else if (hold_vld_eff) begin
        push_vld   = 1'b1;
        push_ent   = hold_ent;
        pend_vld_d = 1'b1;
        pend_d     = hi_ent;
        hold_vld_d = 1'b0;
      end else begin
        push_vld = 1'b1;
        push_ent = hi_ent;
      end
    end else if (flush_req && hold_vld_eff) begin
      push_vld   = 1'b1;
      push_ent   = hold_ent;
      hold_vld_d = 1'b0;
    end
    if (rise) flush_pend_d = 1'b0;
  end

  jtframe_prog_fifo #(.AW(FIFOAW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_vld),
    .din   (push_ent),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // request FSM: GAP is the one-cycle prog_we low; it can reload straight into REQ
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_REQ;
      ST_REQ:  if (prog_rdy) state_d = ST_GAP;
      ST_GAP:  state_d = fifo_empty ? ST_IDLE : ST_REQ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load       = (state_q == ST_IDLE || state_q == ST_GAP) && !fifo_empty;
    pop        = load;
    prog_ent_d = load ? fifo_head : prog_ent_q;
    prog_we_d  = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prog_ent_q   <= '0;
      prog_we_q    <= 1'b0;
      down_q       <= 1'b0;
      hold_vld_q   <= 1'b0;
      hold_ba_q    <= '0;
      hold_word_q  <= '0;
      hold_dat_q   <= '0;
      pend_vld_q   <= 1'b0;
      pend_q       <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prog_ent_q   <= prog_ent_d;
      prog_we_q    <= prog_we_d;
      down_q       <= down_d;
      hold_vld_q   <= hold_vld_d;
      hold_ba_q    <= hold_ba_d;
      hold_word_q  <= hold_word_d;
      hold_dat_q   <= hold_dat_d;
      pend_vld_q   <= pend_vld_d;
      pend_q       <= pend_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
    end
  end

  assign prog_addr   = prog_ent_q.addr[SDRAMW-1:0];
  assign prog_data   = prog_ent_q.data;
  assign prog_mask   = prog_ent_q.mask;
  assign prog_ba     = prog_ent_q.ba;
  assign prog_we     = prog_we_q;
  assign overflow    = overflow_q;
  assign dwnld_busy  = downloading | hold_vld_q | pend_vld_q | flush_pend_q | ~fifo_empty | prog_we_q;
  assign unused_bits = ^{off, prog_ent_q.addr};

endmodule

// File: tb/tb_jtframe_prog_packer.sv
// Directed bench for jtframe_prog_packer: table of byte pairs plus hand sequences for backpressure, overflow and reset.
module tb_jtframe_prog_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask, prog_ba;
  logic        prog_we, dwnld_busy, overflow;
  logic        prog_rdy = 1'b0;

  always #5 clk = ~clk;

`ifdef JTFRAME_PROG_HEADER_EN
  localparam logic [24:0] HOFS = 25'd16;
`else
  localparam logic [24:0] HOFS = 25'd0;
`endif

  jtframe_prog_packer #(.SDRAMW(22), .FIFOAW(2), .HEADER(16)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask), .prog_ba(prog_ba),
    .prog_we(prog_we), .prog_rdy(prog_rdy), .dwnld_busy(dwnld_busy), .overflow(overflow)
  );

  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } wr_t;

  typedef struct {
    int          nb;
    logic [24:0] a0;
    logic [7:0]  d0;
    logic [24:0] a1;
    logic [7:0]  d1;
    int          nw;
    wr_t         w0;
    wr_t         w1;
  } vec_t;

  vec_t vecs[9];
  wr_t  cap[$];
  int   applied = 0, errors = 0;
  bit   auto_rdy = 1'b0, gap_chk = 1'b0, we_prev = 1'b0;
  int   low_cnt = 0, gap_seen = 0, gap_bad = 0, chg_cnt = 0;
  wr_t  last_fields = '0;

  function automatic wr_t mk(input logic [1:0] ba, input logic [21:0] a, input logic [15:0] d, input logic [1:0] m);
    return {ba, a, d, m};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic wr_t cap_at(input int i);
    return (i < cap.size()) ? cap[i] : '1;
  endfunction

  // SDRAM side: pulse prog_rdy for one cycle per request, record the write, watch gaps and stability
  always @(negedge clk) begin
    wr_t cur;
    cur = {prog_ba, prog_addr, prog_data, prog_mask};
    if (prog_we && we_prev && cur !== last_fields) chg_cnt++;
    if (prog_we && !we_prev && gap_chk) begin
      gap_seen++;
      if (low_cnt != 1) gap_bad++;
    end
    low_cnt     = prog_we ? 0 : low_cnt + 1;
    we_prev     = prog_we;
    last_fields = cur;
    if (auto_rdy && prog_we && !prog_rdy) begin
      prog_rdy = 1'b1;
      cap.push_back(cur);
    end else begin
      prog_rdy = 1'b0;
    end
  end

  task automatic send_raw(input logic [24:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    send_raw(a + HOFS, d);
  endtask

  task automatic start_dl();
    @(posedge clk); #1 downloading = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic stop_dl();
    @(posedge clk); #1 downloading = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2, 25'h000_0000, 8'h34, 25'h000_0001, 8'h12, 1, mk(2'd0, 22'h0, 16'h1234, 2'b00), '0};
    vecs[1] = '{1, 25'h010_0005, 8'h56, 25'h0, 8'h00, 1, mk(2'd1, 22'h2, 16'h5656, 2'b01), '0};
    vecs[2] = '{2, 25'h01C_0000, 8'hAA, 25'h000_0000, 8'hBB, 2, mk(2'd3, 22'h0, 16'hAAAA, 2'b10),
                mk(2'd0, 22'h0, 16'hBBBB, 2'b10)};
    vecs[3] = '{2, 25'h000_0003, 8'h11, 25'h000_0004, 8'h22, 2, mk(2'd0, 22'h1, 16'h1111, 2'b01),
                mk(2'd0, 22'h2, 16'h2222, 2'b10)};
    vecs[4] = '{2, 25'h018_0000, 8'hC3, 25'h018_0003, 8'h5A, 2, mk(2'd2, 22'h0, 16'hC3C3, 2'b10),
                mk(2'd2, 22'h1, 16'h5A5A, 2'b01)};
    vecs[5] = '{2, 25'h00F_FFFE, 8'h01, 25'h00F_FFFF, 8'h02, 1, mk(2'd0, 22'h7FFFF, 16'h0201, 2'b00), '0};
    vecs[6] = '{2, 25'h010_0000, 8'hEE, 25'h010_0001, 8'hDD, 1, mk(2'd1, 22'h0, 16'hDDEE, 2'b00), '0};
    vecs[7] = '{1, 25'h017_FFFF, 8'h77, 25'h0, 8'h00, 1, mk(2'd1, 22'h3FFFF, 16'h7777, 2'b01), '0};
    vecs[8] = '{1, 25'h1FF_FFEF, 8'h99, 25'h0, 8'h00, 1, mk(2'd3, 22'h31FFF7, 16'h9999, 2'b01), '0};

    @(posedge clk); #1;
    check("reset outputs", {prog_we, prog_ba, prog_addr, prog_data, prog_mask, overflow, dwnld_busy}, '0);
    repeat (2) @(posedge clk); #1 rst = 1'b0;

    auto_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cap.delete();
      start_dl();
      send(vecs[i].a0, vecs[i].d0);
      if (vecs[i].nb == 2) send(vecs[i].a1, vecs[i].d1);
      stop_dl();
      repeat (12) @(posedge clk); #1;
      check($sformatf("v%0d count", i), cap.size(), vecs[i].nw);
      check($sformatf("v%0d write0", i), cap_at(0), vecs[i].w0);
      if (vecs[i].nw == 2) check($sformatf("v%0d write1", i), cap_at(1), vecs[i].w1);
      check($sformatf("v%0d busy", i), dwnld_busy, 1'b0);
    end

    // controller stalled while four word pairs arrive
    auto_rdy = 1'b0;
    cap.delete();
    chg_cnt = 0;
    start_dl();
    for (int k = 0; k < 8; k++) send(25'h20 + 25'(k), 8'h10 + 8'(k));
    repeat (8) @(posedge clk); #1;
    check("stall overflow", overflow, 1'b0);
    check("stall we", prog_we, 1'b1);
    check("stall head", {prog_ba, prog_addr, prog_data, prog_mask}, mk(2'd0, 22'h10, 16'h1110, 2'b00));
    check("stall stable", chg_cnt, 0);
    gap_seen = 0; gap_bad = 0; gap_chk = 1'b1;
    auto_rdy = 1'b1;
    repeat (20) @(posedge clk); #1;
    gap_chk = 1'b0;
    check("stall count", cap.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("stall write%0d", k), cap_at(k),
            mk(2'd0, 22'h10 + 22'(k), {8'h11 + 8'(2*k), 8'h10 + 8'(2*k)}, 2'b00));
    check("stall gaps", {32'(gap_seen), 32'(gap_bad)}, {32'd3, 32'd0});
    stop_dl();
    repeat (4) @(posedge clk);

    // overflow: 12 full words against a stalled controller, 5 survive
    auto_rdy = 1'b0;
    cap.delete();
    start_dl();
    for (int k = 0; k < 12; k++) begin
      send(25'(2*k), 8'(k));
      send(25'(2*k+1), 8'h80 | 8'(k));
    end
    repeat (4) @(posedge clk); #1;
    check("ovf set", overflow, 1'b1);
    auto_rdy = 1'b1;
    repeat (30) @(posedge clk); #1;
    check("ovf count", cap.size(), 5);
    for (int k = 0; k < 5; k++)
      check($sformatf("ovf write%0d", k), cap_at(k), mk(2'd0, 22'(k), {8'h80 | 8'(k), 8'(k)}, 2'b00));
    stop_dl();
    repeat (3) @(posedge clk); #1;
    check("ovf sticky", overflow, 1'b1);
    start_dl(); #1;
    check("ovf cleared", overflow, 1'b0);
    stop_dl();
    repeat (4) @(posedge clk);

    // lane0 after lane0, then reset in the middle of the request
    auto_rdy = 1'b0;
    cap.delete();
    start_dl();
    send(25'h1C_0000, 8'hAA);
    send(25'h0, 8'hBB);
    repeat (2) @(posedge clk); #1;
    check("rst req we", prog_we, 1'b1);
    check("rst req head", {prog_ba, prog_addr, prog_data, prog_mask}, mk(2'd3, 22'h0, 16'hAAAA, 2'b10));
    #2 rst = 1'b1;
    #1 check("rst async we", prog_we, 1'b0);
    downloading = 1'b0;
    @(posedge clk); #1;
    check("rst busy", dwnld_busy, 1'b0);
    rst = 1'b0;
    auto_rdy = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("rst lost", cap.size(), 0);

`ifdef JTFRAME_PROG_HEADER_EN
    cap.delete();
    start_dl();
    for (int k = 0; k < 16; k++) send_raw(25'(k), 8'hF0 + 8'(k));
    repeat (4) @(posedge clk); #1;
    check("hdr skipped", cap.size(), 0);
    send_raw(25'h10, 8'h01);
    send_raw(25'h11, 8'h02);
    stop_dl();
    repeat (10) @(posedge clk); #1;
    check("hdr count", cap.size(), 1);
    check("hdr write0", cap_at(0), mk(2'd0, 22'h0, 16'h0201, 2'b00));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
